// File: rtl/pipe_tx_gearbox_ctrl.sv
// PIPE TX gearbox controller: registers scrambled beats onto the PIPE TX interface,
// tracks 128b/130b block boundaries and inserts the sync-header stall cycle.
module pipe_tx_gearbox_ctrl (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [2:0]  GEN,
  input  logic [5:0]  PIPEWIDTH,
  input  logic        align_reset,
  input  logic [31:0] scr_data,
  input  logic [3:0]  scr_k,
  input  logic        scr_valid,
  input  logic [1:0]  scr_sync_header,
  output logic        scr_ready,
  output logic [31:0] TxData,
  output logic [3:0]  TxDataK,
  output logic        TxDataValid,
  output logic        TxStartBlock,
  output logic [1:0]  TxSyncHeader
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  beat_q, beat_d, blk_q, blk_d;
  logic [2:0]  gen_q;
  logic [5:0]  pw_q;
  logic [31:0] data_q, data_d;
  logic [3:0]  k_q, k_d;
  logic        valid_q, valid_d, start_q, start_d;
  logic [1:0]  sync_q, sync_d;

  logic        legal_s, restart_s;
  logic [31:0] mask_s;
  logic [3:0]  kmask_s, beat_last_s, blk_last_s, beat_eff_s, blk_eff_s;

  // Width decode: lane mask plus last beat index and last block index before a stall
  always_comb begin
    legal_s     = 1'b1;
    mask_s      = 32'hFFFF_FFFF;
    kmask_s     = 4'b1111;
    beat_last_s = 4'd3;
    blk_last_s  = 4'd15;
    case (PIPEWIDTH)
      6'd8: begin
        mask_s      = 32'h0000_00FF;
        kmask_s     = 4'b0001;
        beat_last_s = 4'd15;
        blk_last_s  = 4'd3;
      end
      6'd16: begin
        mask_s      = 32'h0000_FFFF;
        kmask_s     = 4'b0011;
        beat_last_s = 4'd7;
        blk_last_s  = 4'd7;
      end
      6'd32: begin
        mask_s      = 32'hFFFF_FFFF;
        kmask_s     = 4'b1111;
        beat_last_s = 4'd3;
        blk_last_s  = 4'd15;
      end
      default: begin
        legal_s     = 1'b0;
        mask_s      = 32'h0000_0000;
        kmask_s     = 4'b0000;
        beat_last_s = 4'd0;
        blk_last_s  = 4'd0;
      end
    endcase
  end

  assign scr_ready = (state_q != STALL);
  // A mode change behaves exactly like align_reset.
  assign restart_s  = align_reset | (GEN != gen_q) | (PIPEWIDTH != pw_q);
  assign beat_eff_s = restart_s ? 4'd0 : beat_q;
  assign blk_eff_s  = restart_s ? 4'd0 : blk_q;

  // Next-state, counter and output-register logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    blk_d   = blk_q;
    data_d  = data_q;
    k_d     = k_q;
    valid_d = 1'b0;
    start_d = 1'b0;
    sync_d  = sync_q;
    if (!legal_s) begin
      state_d = IDLE;
      beat_d  = 4'd0;
      blk_d   = 4'd0;
    end else if (GEN < 3'd3) begin
      state_d = IDLE;
      beat_d  = 4'd0;
      blk_d   = 4'd0;
      data_d  = scr_data & mask_s;
      k_d     = scr_k & kmask_s;
      valid_d = scr_valid;
      sync_d  = 2'b00;
    end else begin
      k_d = 4'b0000;
      case (state_q)
        STALL: begin
          state_d = restart_s ? IDLE : RUN;
          beat_d  = 4'd0;
          blk_d   = 4'd0;
        end
        IDLE, RUN: begin
          state_d = restart_s ? IDLE : state_q;
          beat_d  = beat_eff_s;
          blk_d   = blk_eff_s;
          if (scr_valid) begin
            state_d = RUN;
            data_d  = scr_data & mask_s;
            valid_d = 1'b1;
            start_d = (beat_eff_s == 4'd0);
            sync_d  = (beat_eff_s == 4'd0) ? scr_sync_header : 2'b00;
            if (beat_eff_s == beat_last_s) begin
              beat_d = 4'd0;
              if (blk_eff_s == blk_last_s) begin
                blk_d   = 4'd0;
                state_d = STALL;
              end else begin
                blk_d = blk_eff_s + 4'd1;
              end
            end else begin
              beat_d = beat_eff_s + 4'd1;
            end
          end else begin
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          beat_d  = 4'd0;
          blk_d   = 4'd0;
        end
      endcase
    end
  end

  // State, counters, mode history and PIPE output registers
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= 4'd0;
      blk_q   <= 4'd0;
      gen_q   <= 3'd0;
      pw_q    <= 6'd0;
      data_q  <= 32'h0000_0000;
      k_q     <= 4'b0000;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      sync_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
      gen_q   <= GEN;
      pw_q    <= PIPEWIDTH;
      data_q  <= data_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      start_q <= start_d;
      sync_q  <= sync_d;
    end
  end

  assign TxData       = data_q;
  assign TxDataK      = k_q;
  assign TxDataValid  = valid_q;
  assign TxStartBlock = start_q;
  assign TxSyncHeader = sync_q;

endmodule

// File: tb/tb_pipe_tx_gearbox_ctrl.sv
// Self-checking bench for pipe_tx_gearbox_ctrl: directed steps with random data,
// compared every cycle against a beat-counting reference model.
module tb_pipe_tx_gearbox_ctrl;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic [2:0]  GEN;
  logic [5:0]  PIPEWIDTH;
  logic        align_reset;
  logic [31:0] scr_data;
  logic [3:0]  scr_k;
  logic        scr_valid;
  logic [1:0]  scr_sync_header;
  logic        scr_ready;
  logic [31:0] TxData;
  logic [3:0]  TxDataK;
  logic        TxDataValid;
  logic        TxStartBlock;
  logic [1:0]  TxSyncHeader;

  always #5 pclk = ~pclk;

  pipe_tx_gearbox_ctrl dut (
    .pclk(pclk), .reset_n(reset_n), .GEN(GEN), .PIPEWIDTH(PIPEWIDTH),
    .align_reset(align_reset), .scr_data(scr_data), .scr_k(scr_k),
    .scr_valid(scr_valid), .scr_sync_header(scr_sync_header), .scr_ready(scr_ready),
    .TxData(TxData), .TxDataK(TxDataK), .TxDataValid(TxDataValid),
    .TxStartBlock(TxStartBlock), .TxSyncHeader(TxSyncHeader)
  );

  int total = 0;
  int passed = 0;
  int fails = 0;

  // Reference model: n = beats accepted since the current stall group began
  int          n = 0;
  bit          stall_m = 1'b0;
  logic [31:0] m_data = 32'h0;
  logic [3:0]  m_k = 4'h0;
  logic        m_valid = 1'b0, m_start = 1'b0;
  logic [1:0]  m_sync = 2'b00;
  logic [2:0]  pgen = 3'd0;
  logic [5:0]  ppw = 6'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit legal, restart, st;
    int pw, bpb, bps;
    logic [31:0] msk;
    logic [3:0] kmsk;
    pw    = int'(PIPEWIDTH);
    legal = (pw == 8) || (pw == 16) || (pw == 32);
    bpb   = legal ? 16 / (pw / 8) : 1;
    bps   = pw / 2;
    msk   = (pw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << pw) - 32'h1);
    kmsk  = legal ? 4'((5'h1 << (pw / 8)) - 5'h1) : 4'h0;
    if (reset_n) chk("scr_ready", {31'h0, scr_ready}, {31'h0, !stall_m});
    if (!reset_n) begin
      n = 0; stall_m = 0; m_data = 32'h0; m_k = 4'h0;
      m_valid = 0; m_start = 0; m_sync = 2'b00; pgen = 3'd0; ppw = 6'd0;
    end else begin
      restart = align_reset || (GEN != pgen) || (PIPEWIDTH != ppw);
      pgen = GEN; ppw = PIPEWIDTH;
      m_valid = 0; m_start = 0;
      if (!legal) begin
        n = 0; stall_m = 0;
      end else if (GEN < 3'd3) begin
        n = 0; stall_m = 0;
        m_data = scr_data & msk; m_k = scr_k & kmsk; m_valid = scr_valid; m_sync = 2'b00;
      end else begin
        m_k = 4'h0;
        if (stall_m) begin
          stall_m = 0; n = 0;
        end else begin
          if (restart) n = 0;
          if (scr_valid) begin
            st = (n % bpb) == 0;
            m_data = scr_data & msk; m_valid = 1; m_start = st;
            m_sync = st ? scr_sync_header : 2'b00;
            n++;
            if (n == bpb * bps) begin
              n = 0; stall_m = 1;
            end
          end
        end
      end
    end
    @(posedge pclk); #1;
    chk("TxData", TxData, m_data);
    chk("TxDataK", {28'h0, TxDataK}, {28'h0, m_k});
    chk("TxDataValid", {31'h0, TxDataValid}, {31'h0, m_valid});
    chk("TxStartBlock", {31'h0, TxStartBlock}, {31'h0, m_start});
    chk("TxSyncHeader", {30'h0, TxSyncHeader}, {30'h0, m_sync});
  endtask

  task automatic rnd_beat(input logic v);
    scr_data = $urandom; scr_k = 4'($urandom_range(0, 15)); scr_valid = v;
  endtask

  initial begin
    reset_n = 1'b0; GEN = 3'd1; PIPEWIDTH = 6'd32; align_reset = 1'b0;
    scr_data = 32'h0; scr_k = 4'h0; scr_valid = 1'b0; scr_sync_header = 2'b01;
    // Reset then idle
    step(); step();
    reset_n = 1'b1;
    step(); step();
    chk("reset_ready", {31'h0, scr_ready}, 32'h1);

    // Gen1 pass-through
    scr_data = 32'hFDBABAFB; scr_k = 4'b1001; scr_valid = 1'b1;
    step();
    chk("gen1_data", TxData, 32'hFDBABAFB);
    chk("gen1_k", {28'h0, TxDataK}, 32'h9);
    for (int i = 0; i < 20; i++) begin rnd_beat(1'b1); step(); end
    PIPEWIDTH = 6'd8;
    for (int i = 0; i < 10; i++) begin rnd_beat(1'($urandom_range(0, 1))); step(); end

    // Gen3 x32, continuous valid, data blocks
    GEN = 3'd3; PIPEWIDTH = 6'd32; scr_valid = 1'b0; step();
    scr_sync_header = 2'b01;
    for (int i = 0; i < 140; i++) begin rnd_beat(1'b1); step(); end

    // Gen3 x8 and x16
    scr_valid = 1'b0; PIPEWIDTH = 6'd8; step();
    for (int i = 0; i < 140; i++) begin rnd_beat(1'b1); step(); end
    scr_valid = 1'b0; PIPEWIDTH = 6'd16; step();
    for (int i = 0; i < 140; i++) begin rnd_beat(1'b1); step(); end

    // Gap of 3 cycles at beat 2 of a block
    scr_valid = 1'b0; align_reset = 1'b1; step(); align_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin rnd_beat(1'b1); step(); end
    for (int i = 0; i < 3; i++) begin rnd_beat(1'b0); step(); end
    for (int i = 0; i < 80; i++) begin rnd_beat(1'b1); step(); end

    // align_reset at beat 5 of 8
    scr_valid = 1'b0; align_reset = 1'b1; step(); align_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin rnd_beat(1'b1); step(); end
    rnd_beat(1'b1); align_reset = 1'b1; scr_sync_header = 2'b10; step();
    align_reset = 1'b0;
    chk("align_start", {31'h0, TxStartBlock}, 32'h1);
    chk("align_sync", {30'h0, TxSyncHeader}, 32'h2);
    scr_sync_header = 2'b01;
    for (int i = 0; i < 70; i++) begin rnd_beat(1'b1); step(); end

    // Reset during a stall cycle
    begin
      int budget = 200;
      while (!stall_m && budget > 0) begin rnd_beat(1'b1); step(); budget--; end
      chk("stall_reached", {31'h0, stall_m}, 32'h1);
    end
    reset_n = 1'b0; step(); reset_n = 1'b1;
    GEN = 3'd3; PIPEWIDTH = 6'd16; rnd_beat(1'b1); step();
    chk("post_reset_start", {31'h0, TxStartBlock}, 32'h1);
    for (int i = 0; i < 70; i++) begin rnd_beat(1'b1); step(); end

    // Random mix: gaps, align pulses, headers, Gen5 x32
    GEN = 3'd5; PIPEWIDTH = 6'd32; scr_valid = 1'b0; step();
    for (int i = 0; i < 400; i++) begin
      rnd_beat(1'($urandom_range(0, 3) != 0));
      align_reset = ($urandom_range(0, 40) == 0);
      scr_sync_header = 2'($urandom_range(1, 2));
      step();
    end
    align_reset = 1'b0;

    // Illegal width
    scr_valid = 1'b0; step();
    PIPEWIDTH = 6'd12;
    for (int i = 0; i < 6; i++) begin rnd_beat(1'b1); step(); end
    chk("illegal_ready", {31'h0, scr_ready}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
